// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DIV_W_DEF = 16;

    typedef logic [DIV_W_DEF-1:0] div_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Length of the high phase: odd divisors get the extra cycle high.
    function automatic div_t hi_len(input div_t d);
        logic [DIV_W_DEF:0] sum;
        sum = {1'b0, d} + (DIV_W_DEF+1)'(1);
        return sum[DIV_W_DEF:1];
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, shadow divisor with boundary apply, registered outputs.
//   state   | meaning
//   CH_IDLE | channel disabled, counter parked at 0, outputs low
//   CH_RUN  | channel enabled, counting 0..div_run-1 (halted while div_run==0)
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [DIV_W-1:0] ld_div,
    output logic             clk_out,
    output logic             tick,
    output logic             upd_pending
);

    ch_state_t        state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_run, div_run_nxt;
    logic [DIV_W-1:0] div_shadow, div_shadow_nxt;
    logic             pending, pending_nxt;
    logic             running, wrap, apply, live;
    logic             tick_nxt, clk_nxt;
    logic [DIV_W:0]   hi_sum;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        div_run_nxt    = div_run;
        div_shadow_nxt = div_shadow;
        pending_nxt    = pending;

        running = (state == CH_RUN) && (div_run != '0);
        wrap    = running && (cnt == div_run - DIV_W'(1));
        // Applying when idle or halted is safe: no period is in flight.
        apply   = (pending && wrap) || (state == CH_IDLE) || (div_run == '0);

        if (apply) begin
            div_run_nxt = div_shadow;
            pending_nxt = 1'b0;
        end
        // A write on an apply edge lands in the shadow for the next boundary.
        if (ld) begin
            div_shadow_nxt = ld_div;
            pending_nxt    = 1'b1;
        end

        case (state)
            CH_IDLE: begin
                cnt_nxt = '0;
                if (en) state_nxt = CH_RUN;
            end
            CH_RUN: begin
                if (!en) begin
                    state_nxt = CH_IDLE;
                    cnt_nxt   = '0;
                end else if (!running || wrap) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = CH_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        hi_sum   = {1'b0, div_run_nxt} + (DIV_W+1)'(1);
        live     = (state_nxt == CH_RUN) && (div_run_nxt != '0);
        tick_nxt = live && (cnt_nxt == '0);
        clk_nxt  = live && (cnt_nxt < hi_sum[DIV_W:1]);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state       <= CH_IDLE;
            cnt         <= '0;
            div_run     <= DIV_W'(DEFAULT_DIV);
            div_shadow  <= DIV_W'(DEFAULT_DIV);
            pending     <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            upd_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            div_run     <= div_run_nxt;
            div_shadow  <= div_shadow_nxt;
            pending     <= pending_nxt;
            clk_out     <= clk_nxt;
            tick        <= tick_nxt;
            upd_pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode plus one clk_div_chan per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] upd_pending
);

    logic [NUM_CH-1:0] ld;

    // Out-of-range channel numbers match no index and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ld[g] = wr_en && (wr_ch == CH_W'(g));

        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .en          (ch_en[g]),
            .ld          (ld[g]),
            .ld_div      (wr_div),
            .clk_out     (clk_out[g]),
            .tick        (tick[g]),
            .upd_pending (upd_pending[g])
        );
    end

endmodule
